// File: rtl/imem_arbiter.sv
// Two-port arbiter for the instruction memory read port: fetch (F) has fixed
// priority, debug (D) is protected by a starvation guard, fetch supports flush.
module imem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ready,
  input  logic              f_flush,
  output logic              f_rsp_valid,
  output logic [31:0]       f_rsp_data,
  output logic              f_rsp_err,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_ready,
  output logic              d_rsp_valid,
  output logic [31:0]       d_rsp_data,
  output logic              d_rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_instr
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 32;
  localparam logic        PORT_F = 1'b0;
  localparam logic        PORT_D = 1'b1;

  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_s1_valid;
  logic              r_s1_port;
  logic [ADDR_W-1:0] r_s1_addr;
  logic              r_s1_err;
  logic              r_s2_f_valid;
  logic              r_s2_d_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;

  logic              w_starve;
  logic              w_accept;
  logic [ADDR_W-1:0] w_sel_addr;

  // Grant: fetch first unless debug has lost STARVE_LIMIT times in a row.
  assign w_starve   = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
  assign f_ready    = rst_n & f_req & ~f_flush & ~(d_req & w_starve);
  assign d_ready    = rst_n & d_req & ~f_ready;
  assign w_accept   = f_ready | d_ready;
  assign w_sel_addr = f_ready ? f_addr : d_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!d_req || d_ready) begin
      r_starve_cnt <= '0;
    end else if (!w_starve) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  // Issue stage; address and error hold when idle so mem_addr stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_port  <= PORT_F;
      r_s1_addr  <= '0;
      r_s1_err   <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_port <= f_ready ? PORT_F : PORT_D;
        r_s1_addr <= w_sel_addr;
        r_s1_err  <= (w_sel_addr >= ADDR_W'(DEPTH));
      end
    end
  end

  assign mem_addr  = r_s1_addr;
  assign mem_rd_en = r_s1_valid & ~r_s1_err;

  // Response stage; a flush drops any fetch still in the issue stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_f_valid <= 1'b0;
      r_s2_d_valid <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_s2_f_valid <= r_s1_valid & (r_s1_port == PORT_F) & ~f_flush;
      r_s2_d_valid <= r_s1_valid & (r_s1_port == PORT_D);
      if (r_s1_valid) begin
        r_rsp_data <= r_s1_err ? '0 : mem_instr;
        r_rsp_err  <= r_s1_err;
      end
    end
  end

  assign f_rsp_valid = r_s2_f_valid & ~f_flush;
  assign f_rsp_data  = r_rsp_data;
  assign f_rsp_err   = r_rsp_err;
  assign d_rsp_valid = r_s2_d_valid;
  assign d_rsp_data  = r_rsp_data;
  assign d_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: tasks push expected responses when they
// drive requests; a negedge monitor pops and compares data, err and arrival cycle.
module tb_imem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 1024;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              f_req, f_flush, d_req;
  logic [ADDR_W-1:0] f_addr, d_addr;
  logic              f_ready, d_ready;
  logic              f_rsp_valid, d_rsp_valid;
  logic [31:0]       f_rsp_data, d_rsp_data;
  logic              f_rsp_err, d_rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_instr = 32'h0;

  logic [31:0] mem [0:DEPTH-1];
  exp_t        f_q[$];
  exp_t        d_q[$];
  exp_t        ef, ed;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_ready(f_ready), .f_flush(f_flush),
    .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data), .f_rsp_err(f_rsp_err),
    .d_req(d_req), .d_addr(d_addr), .d_ready(d_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_instr(mem_instr)
  );

  // Memory model: captures on the falling edge when enabled.
  always @(negedge clk) if (mem_rd_en) mem_instr <= mem[mem_addr[9:0]];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [ADDR_W-1:0] a, input int due);
    exp_t e;
    e.err  = (a >= ADDR_W'(DEPTH));
    e.data = e.err ? 32'h0 : mem[a[9:0]];
    e.due  = due;
    return e;
  endfunction

  // Response monitor.
  always @(negedge clk) begin
    if (f_rsp_valid === 1'b1) begin
      n_tests++;
      if (f_q.size() == 0) begin
        n_fail++;
        $display("FAIL f_rsp_unexpected: got data=%h err=%b at cycle %0d, required no response", f_rsp_data, f_rsp_err, cyc);
      end else begin
        ef = f_q.pop_front();
        if (f_rsp_data !== ef.data || f_rsp_err !== ef.err || cyc != ef.due) begin
          n_fail++;
          $display("FAIL f_rsp: got data=%h err=%b cycle=%0d, required data=%h err=%b cycle=%0d", f_rsp_data, f_rsp_err, cyc, ef.data, ef.err, ef.due);
        end
      end
    end
    if (d_rsp_valid === 1'b1) begin
      n_tests++;
      if (d_q.size() == 0) begin
        n_fail++;
        $display("FAIL d_rsp_unexpected: got data=%h err=%b at cycle %0d, required no response", d_rsp_data, d_rsp_err, cyc);
      end else begin
        ed = d_q.pop_front();
        if (d_rsp_data !== ed.data || d_rsp_err !== ed.err || cyc != ed.due) begin
          n_fail++;
          $display("FAIL d_rsp: got data=%h err=%b cycle=%0d, required data=%h err=%b cycle=%0d", d_rsp_data, d_rsp_err, cyc, ed.data, ed.err, ed.due);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    f_req = 1'b0; d_req = 1'b0; f_flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; f_req = 1'b1; d_req = 1'b1; f_flush = 1'b0;
    f_addr = 32'd5; d_addr = 32'd6;
    #2;
    n_tests++;
    if ({f_ready, d_ready, f_rsp_valid, d_rsp_valid, mem_rd_en, f_rsp_err, d_rsp_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, required 0000000", {f_ready, d_ready, f_rsp_valid, d_rsp_valid, mem_rd_en, f_rsp_err, d_rsp_err});
    end
    n_tests++;
    if (mem_addr !== 32'h0 || f_rsp_data !== 32'h0 || d_rsp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h fdata=%h ddata=%h, required 0", mem_addr, f_rsp_data, d_rsp_data);
    end
    tick();
    idle();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch_seq();
    for (int i = 0; i < 3; i++) begin
      f_req = 1'b1; f_addr = ADDR_W'(i);
      #1;
      n_tests++;
      if (f_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL fetch_seq_ready[%0d]: got %b, required 1", i, f_ready);
      end
      f_q.push_back(mk(f_addr, cyc + 2));
      tick();
    end
    idle();
    repeat (4) tick();
    n_tests++;
    if (f_q.size() != 0) begin n_fail++; $display("FAIL fetch_seq_drain: got %0d pending, required 0", f_q.size()); end
  endtask

  task automatic test_starve();
    logic exp_f;
    for (int i = 0; i < 10; i++) begin
      f_req = 1'b1; d_req = 1'b1;
      f_addr = ADDR_W'(100 + i); d_addr = 32'd200;
      #1;
      exp_f = (i != 8);
      n_tests++;
      if (f_ready !== exp_f || d_ready !== !exp_f) begin
        n_fail++;
        $display("FAIL starve_grant[%0d]: got f=%b d=%b, required f=%b d=%b", i, f_ready, d_ready, exp_f, !exp_f);
      end
      if (exp_f) f_q.push_back(mk(f_addr, cyc + 2));
      else       d_q.push_back(mk(d_addr, cyc + 2));
      tick();
    end
    idle();
    repeat (4) tick();
    n_tests++;
    if (f_q.size() != 0 || d_q.size() != 0) begin
      n_fail++; $display("FAIL starve_drain: got %0d/%0d pending, required 0/0", f_q.size(), d_q.size());
    end
  endtask

  task automatic test_oob();
    d_req = 1'b1; d_addr = 32'd1023;
    #1;
    n_tests++;
    if (d_ready !== 1'b1) begin n_fail++; $display("FAIL oob_ready_1023: got %b, required 1", d_ready); end
    d_q.push_back(mk(d_addr, cyc + 2));
    tick();
    d_addr = 32'd1024;
    #1;
    n_tests++;
    if (d_ready !== 1'b1) begin n_fail++; $display("FAIL oob_ready_1024: got %b, required 1", d_ready); end
    n_tests++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 32'd1023) begin
      n_fail++; $display("FAIL oob_issue_1023: got en=%b addr=%0d, required en=1 addr=1023", mem_rd_en, mem_addr);
    end
    d_q.push_back(mk(d_addr, cyc + 2));
    tick();
    idle();
    #1;
    n_tests++;
    if (mem_rd_en !== 1'b0 || mem_addr !== 32'd1024) begin
      n_fail++; $display("FAIL oob_issue_1024: got en=%b addr=%0d, required en=0 addr=1024", mem_rd_en, mem_addr);
    end
    repeat (4) tick();
    n_tests++;
    if (d_q.size() != 0) begin n_fail++; $display("FAIL oob_drain: got %0d pending, required 0", d_q.size()); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      f_req = 1'b1; f_addr = ADDR_W'(20 + i);
      #1;
      n_tests++;
      if (f_ready !== 1'b1) begin n_fail++; $display("FAIL flush_pre_ready[%0d]: got %b, required 1", i, f_ready); end
      tick();
    end
    f_flush = 1'b1; f_addr = 32'd22;
    #1;
    n_tests++;
    if (f_ready !== 1'b0 || f_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_cycle: got ready=%b rsp_valid=%b, required 0 0", f_ready, f_rsp_valid);
    end
    tick();
    f_flush = 1'b0; f_addr = 32'd23;
    #1;
    n_tests++;
    if (f_rsp_valid !== 1'b0 || f_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_after: got rsp_valid=%b ready=%b, required 0 1", f_rsp_valid, f_ready);
    end
    f_q.push_back(mk(f_addr, cyc + 2));
    tick();
    idle();
    repeat (4) tick();
    n_tests++;
    if (f_q.size() != 0) begin n_fail++; $display("FAIL flush_drain: got %0d pending, required 0", f_q.size()); end
  endtask

  task automatic test_flush_debug();
    d_req = 1'b1; d_addr = 32'd30;
    #1;
    n_tests++;
    if (d_ready !== 1'b1) begin n_fail++; $display("FAIL flushdbg_ready: got %b, required 1", d_ready); end
    d_q.push_back(mk(d_addr, cyc + 2));
    tick();
    d_req = 1'b0; f_flush = 1'b1;
    tick();
    tick();
    idle();
    repeat (3) tick();
    n_tests++;
    if (d_q.size() != 0) begin n_fail++; $display("FAIL flushdbg_drain: got %0d pending, required 0", d_q.size()); end
  endtask

  task automatic test_back_to_back();
    // F and D both request with no starvation: F wins, D follows next cycle.
    f_req = 1'b1; d_req = 1'b1; f_addr = 32'd5; d_addr = 32'd6;
    #1;
    n_tests++;
    if (f_ready !== 1'b1 || d_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_prio: got f=%b d=%b, required f=1 d=0", f_ready, d_ready);
    end
    f_q.push_back(mk(f_addr, cyc + 2));
    tick();
    f_req = 1'b0;
    #1;
    n_tests++;
    if (d_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_d: got %b, required 1", d_ready); end
    d_q.push_back(mk(d_addr, cyc + 2));
    tick();
    d_req = 1'b0; f_req = 1'b1; f_addr = 32'd7;
    #1;
    f_q.push_back(mk(f_addr, cyc + 2));
    tick();
    idle();
    repeat (4) tick();
    n_tests++;
    if (f_q.size() != 0 || d_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_drain: got %0d/%0d pending, required 0/0", f_q.size(), d_q.size());
    end
  endtask

  task automatic test_reset_mid();
    f_req = 1'b1; f_addr = 32'd40;
    tick();
    f_req = 1'b0; d_req = 1'b1; d_addr = 32'd41;
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({f_ready, d_ready, f_rsp_valid, d_rsp_valid, mem_rd_en, f_rsp_err, d_rsp_err} !== 7'b0 ||
        mem_addr !== 32'h0 || f_rsp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got ctrl=%b addr=%h data=%h, required all 0",
               {f_ready, d_ready, f_rsp_valid, d_rsp_valid, mem_rd_en, f_rsp_err, d_rsp_err}, mem_addr, f_rsp_data);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    f_req = 1'b1; f_addr = 32'd3;
    #1;
    n_tests++;
    if (f_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_ready: got %b, required 1", f_ready); end
    f_q.push_back(mk(f_addr, cyc + 2));
    tick();
    idle();
    repeat (4) tick();
    n_tests++;
    if (f_q.size() != 0 || d_q.size() != 0) begin
      n_fail++; $display("FAIL reset_mid_drain: got %0d/%0d pending, required 0/0", f_q.size(), d_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0013);
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    mem[2] = 32'h0020_0113;
    mem[1023] = 32'hDEAD_BEEF;
    test_reset();
    test_fetch_seq();
    test_starve();
    test_oob();
    test_flush();
    test_flush_debug();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000, required completion");
    $fatal(1);
  end

endmodule
